// File: rtl/uart_frame_parser.sv
// uart_frame_parser
//   Extracts SYNC/LEN/payload/XOR-checksum frames from a UART byte strobe and
//   queues the payload of good frames in a FIFO presented as a valid/ready stream.
//   A frame is atomic: it becomes visible only when its checksum matches.
// Ports
//   clk, reset       clock, asynchronous active-high reset
//   rx_done, rx_byte byte strobe and byte from the UART receiver
//   out_data/out_last/out_valid/out_ready  show-ahead payload stream
//   frame_ok, frame_err  one-cycle result pulses
//   err_code         reason of the last dropped frame (0 csum, 1 len, 2 overflow, 3 timeout)
//   busy             parser is inside a frame
module uart_frame_parser #(
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned MAX_LEN     = 16,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned TIMEOUT_CYC = 11520
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done,
    input  logic [7:0] rx_byte,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_LEN, S_DATA, S_CSUM} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   rd_ptr, cwr_ptr, twr_ptr, cwr_nxt, twr_nxt;
    logic [7:0]      remaining, remaining_nxt;
    logic [7:0]      csum, csum_nxt;
    logic [TW-1:0]   timer, timer_nxt;
    logic            ok_nxt, err_nxt;
    logic [1:0]      code_nxt;
    logic            wr_en_c;
    logic            timeout_c;
    logic            rd_en_c;
    logic [PW-1:0]   used_c;
    logic [8:0]      free_c;
    logic [8:0]      mem [FIFO_DEPTH];
    logic [8:0]      head_c;

    assign used_c    = cwr_ptr - rd_ptr;
    assign free_c    = 9'(FIFO_DEPTH) - 9'(used_c);
    assign out_valid = (cwr_ptr != rd_ptr);
    assign rd_en_c   = out_valid & out_ready;
    assign head_c    = mem[rd_ptr[AW-1:0]];
    // Head is forced to zero while empty so the stream reads as idle after reset.
    assign out_data  = out_valid ? head_c[7:0] : 8'h00;
    assign out_last  = out_valid & head_c[8];
    assign busy      = (state != S_IDLE);
    // A byte arriving on the expiry cycle wins over the timeout.
    assign timeout_c = (state != S_IDLE) && !rx_done && (timer == TW'(TIMEOUT_CYC));

    // State register and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            rd_ptr    <= '0;
            cwr_ptr   <= '0;
            twr_ptr   <= '0;
            remaining <= '0;
            csum      <= '0;
            timer     <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            state     <= state_nxt;
            cwr_ptr   <= cwr_nxt;
            twr_ptr   <= twr_nxt;
            remaining <= remaining_nxt;
            csum      <= csum_nxt;
            timer     <= timer_nxt;
            frame_ok  <= ok_nxt;
            frame_err <= err_nxt;
            err_code  <= code_nxt;
            if (rd_en_c) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Payload storage; no reset needed since contents are only read behind cwr_ptr
    always_ff @(posedge clk) begin
        if (wr_en_c) mem[twr_ptr[AW-1:0]] <= {(remaining == 8'd1), rx_byte};
    end

    // Next-state and datapath control
    always_comb begin
        state_nxt     = state;
        cwr_nxt       = cwr_ptr;
        twr_nxt       = twr_ptr;
        remaining_nxt = remaining;
        csum_nxt      = csum;
        ok_nxt        = 1'b0;
        err_nxt       = 1'b0;
        code_nxt      = err_code;
        wr_en_c       = 1'b0;
        timer_nxt     = (rx_done || state == S_IDLE || timeout_c) ? '0 : timer + TW'(1);

        if (timeout_c) begin
            err_nxt   = 1'b1;
            code_nxt  = 2'd3;
            twr_nxt   = cwr_ptr;
            state_nxt = S_IDLE;
        end else if (rx_done) begin
            case (state)
                S_IDLE: begin
                    if (rx_byte == SYNC_BYTE) state_nxt = S_LEN;
                end
                S_LEN: begin
                    if (rx_byte == 8'd0 || rx_byte > 8'(MAX_LEN)) begin
                        err_nxt   = 1'b1;
                        code_nxt  = 2'd1;
                        state_nxt = S_IDLE;
                    end else if (free_c < 9'(rx_byte)) begin
                        err_nxt   = 1'b1;
                        code_nxt  = 2'd2;
                        state_nxt = S_IDLE;
                    end else begin
                        remaining_nxt = rx_byte;
                        csum_nxt      = rx_byte;
                        twr_nxt       = cwr_ptr;
                        state_nxt     = S_DATA;
                    end
                end
                S_DATA: begin
                    wr_en_c       = 1'b1;
                    twr_nxt       = twr_ptr + PW'(1);
                    csum_nxt      = csum ^ rx_byte;
                    remaining_nxt = remaining - 8'd1;
                    if (remaining == 8'd1) state_nxt = S_CSUM;
                end
                S_CSUM: begin
                    if (rx_byte == csum) begin
                        cwr_nxt = twr_ptr;
                        ok_nxt  = 1'b1;
                    end else begin
                        twr_nxt  = cwr_ptr;
                        err_nxt  = 1'b1;
                        code_nxt = 2'd0;
                    end
                    state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Testbench for uart_frame_parser: drives framed byte streams and checks the
// payload stream and frame result pulses against expectation queues.
module tb_uart_frame_parser;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_done = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_valid;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;

    localparam int EV_OK = 4;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [8:0] dq [$];
    int         evq [$];
    logic [7:0] pl [$];
    logic [8:0] mon_v;
    int         mon_e;

    uart_frame_parser dut (
        .clk       (clk),
        .reset     (reset),
        .rx_done   (rx_done),
        .rx_byte   (rx_byte),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output stream and result pulse monitor
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            chk("out_expected", 32'(dq.size() != 0), 1);
            if (dq.size() != 0) begin
                mon_v = dq.pop_front();
                chk("out_data", 32'(out_data), 32'(mon_v[7:0]));
                chk("out_last", 32'(out_last), 32'(mon_v[8]));
            end
        end
        if (frame_ok || frame_err) begin
            chk("event_expected", 32'(evq.size() != 0), 1);
            if (evq.size() != 0) begin
                mon_e = evq.pop_front();
                if (mon_e == EV_OK) begin
                    chk("frame_ok", 32'({frame_err, frame_ok}), 32'b01);
                end else begin
                    chk("frame_err", 32'({frame_err, frame_ok}), 32'b10);
                    chk("err_code", 32'(err_code), 32'(mon_e));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick();
        rx_done = 1'b1;
        rx_byte = b;
        tick();
        rx_done = 1'b0;
        tick();
        tick();
    endtask

    // Sends the frame held in pl; checksum covers LEN and payload.
    task automatic send_frame(input bit bad);
        logic [7:0] cs;
        cs = 8'(pl.size());
        send_byte(8'hA5);
        send_byte(cs);
        for (int i = 0; i < pl.size(); i++) begin
            send_byte(pl[i]);
            cs ^= pl[i];
        end
        if (bad) begin
            cs ^= 8'h07;
            evq.push_back(0);
        end else begin
            evq.push_back(EV_OK);
            for (int i = 0; i < pl.size(); i++)
                dq.push_back({1'(i == pl.size() - 1), pl[i]});
        end
        send_byte(cs);
    endtask

    task automatic wait_events(input int max_cyc);
        for (int k = 0; k < max_cyc && evq.size() != 0; k++) tick();
        chk("events_timeout", 32'(evq.size()), 0);
    endtask

    task automatic wait_drain(input int max_cyc);
        for (int k = 0; k < max_cyc && (dq.size() != 0 || evq.size() != 0); k++) tick();
        chk("drain_timeout", 32'(dq.size() + evq.size()), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_frame_ok", 32'(frame_ok), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_err_code", 32'(err_code), 0);
        chk("rst_busy", 32'(busy), 0);
        reset = 1'b0;
        out_ready = 1'b1;
        tick();

        // Good 3-byte frame
        pl = '{8'h11, 8'h22, 8'h33};
        send_frame(1'b0);
        wait_drain(50);
        chk("t1_err_code", 32'(err_code), 0);
        chk("t1_busy", 32'(busy), 0);

        // Bad checksum, then good 1-byte frame
        send_frame(1'b1);
        wait_drain(50);
        chk("t2_out_valid", 32'(out_valid), 0);
        pl = '{8'h7E};
        send_frame(1'b0);
        wait_drain(50);

        // Length errors and hunting
        evq.push_back(1);
        send_byte(8'hA5);
        send_byte(8'h00);
        wait_events(50);
        chk("t3_busy_a", 32'(busy), 0);
        evq.push_back(1);
        send_byte(8'hA5);
        send_byte(8'h11);
        wait_events(50);
        chk("t3_busy_b", 32'(busy), 0);
        send_byte(8'h33);
        send_byte(8'h44);
        chk("t3_hunt_busy", 32'(busy), 0);

        // Largest legal frame into an empty FIFO
        pl.delete();
        for (int i = 0; i < 16; i++) pl.push_back(8'($urandom_range(0, 255)));
        send_frame(1'b0);
        wait_drain(100);

        // Inter-byte timeout
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h11);
        evq.push_back(3);
        repeat (11400) tick();
        chk("t4_no_early_timeout", 32'(evq.size()), 1);
        chk("t4_busy_waiting", 32'(busy), 1);
        wait_events(400);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_out_valid", 32'(out_valid), 0);
        pl = '{8'h5C};
        send_frame(1'b0);
        wait_drain(50);

        // Overflow while consumer stalls
        out_ready = 1'b0;
        pl.delete();
        for (int i = 0; i < 12; i++) pl.push_back(8'(8'h30 + i));
        send_frame(1'b0);
        wait_events(50);
        chk("t5_out_valid", 32'(out_valid), 1);
        evq.push_back(2);
        send_byte(8'hA5);
        send_byte(8'h08);
        wait_events(50);
        chk("t5_err_code", 32'(err_code), 2);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_held", 32'(dq.size()), 12);
        out_ready = 1'b1;
        wait_drain(100);
        chk("t5_empty", 32'(out_valid), 0);

        // Garbage then SYNC bytes as payload
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        chk("t6_garbage_busy", 32'(busy), 0);
        pl = '{8'hA5, 8'hA5};
        send_frame(1'b0);
        wait_drain(50);

        // Reset mid-DATA with committed data still queued
        out_ready = 1'b0;
        pl = '{8'h01, 8'h02};
        send_frame(1'b0);
        wait_events(50);
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h11);
        send_byte(8'h22);
        chk("t6_mid_busy", 32'(busy), 1);
        reset = 1'b1;
        dq.delete();
        evq.delete();
        #2;
        chk("t6_rst_out_valid", 32'(out_valid), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_err_code", 32'(err_code), 0);
        chk("t6_rst_out_data", 32'(out_data), 0);
        chk("t6_rst_pulses", 32'({frame_ok, frame_err}), 0);
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        pl = '{8'h3C, 8'hC3};
        send_frame(1'b0);
        wait_drain(50);
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
